// File: rtl/ula181_nibble_sequencer.sv
// Runs one 4-bit 74181 slice serially over WIDTH/4 nibbles, LSB first, chaining Cn4 into the next Cn.
// Latency NIB+1 cycles from accepted start to done; start is ignored outside IDLE (no queueing).
module ula181_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_s,
  input  logic             op_m,
  input  logic             op_cn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             aeq,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cn,
  input  logic [3:0]       alu_f,
  input  logic             alu_cn4,
  input  logic             alu_aeqb
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_chk
    $error("ula181_nibble_sequencer: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [3:0]       r_s;
  logic             r_m;
  logic             r_cn;
  logic             r_cout;
  logic             r_aeq;
  logic             r_busy;
  logic             r_done;
  logic             w_last;

  assign w_last = (r_k == KW'(NIB - 1));

  // Operand registers shift down one nibble per step, so the slice always sees bits [3:0];
  // they stop shifting on the last nibble so alu_a/alu_b hold their final value afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_s     <= '0;
      r_m     <= 1'b0;
      r_cn    <= 1'b0;
      r_cout  <= 1'b0;
      r_aeq   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_s     <= op_s;
            r_m     <= op_m;
            r_cn    <= op_cn;
            r_aeq   <= 1'b1;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Nibbles enter at the top; after NIB steps nibble 0 sits at bits [3:0].
          r_res <= {alu_f, r_res[WIDTH-1:4]};
          r_aeq <= r_aeq & alu_aeqb;
          if (w_last) begin
            r_cout  <= alu_cn4;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cn <= alu_cn4;
            r_a  <= r_a >> 4;
            r_b  <= r_b >> 4;
            r_k  <= r_k + 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_res;
  assign cout   = r_cout;
  assign aeq    = r_aeq;
  assign alu_a  = r_a[3:0];
  assign alu_b  = r_b[3:0];
  assign alu_s  = r_s;
  assign alu_m  = r_m;
  assign alu_cn = r_cn;

endmodule

// File: tb/tb_ula181_nibble_sequencer.sv
// Bench for ula181_nibble_sequencer: a behavioural 74181 slice (active-high carry) is attached,
// expected results are queued at issue and checked by a done-triggered monitor.
module tb_ula181_nibble_sequencer;

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        aeq;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [3:0]  op_s = '0;
  logic        op_m = 1'b0;
  logic        op_cn = 1'b0;
  logic        busy, done, cout, aeq;
  logic [15:0] result;
  logic [3:0]  alu_a, alu_b, alu_s, alu_f;
  logic        alu_m, alu_cn, alu_cn4, alu_aeqb;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;

  always #5 clk = ~clk;

  ula181_nibble_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cn(op_cn),
    .busy(busy), .done(done), .result(result), .cout(cout), .aeq(aeq),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
    .alu_f(alu_f), .alu_cn4(alu_cn4), .alu_aeqb(alu_aeqb)
  );

  // Returns {aeqb, cn4, f}; arithmetic is x + y + cn with cn=1 meaning carry in.
  function automatic logic [5:0] slice(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] s, input logic m, input logic cn);
    logic [3:0] x, y, f;
    logic [4:0] sum;
    logic       c4;
    x = a; y = 4'h0; f = 4'h0; c4 = 1'b0; sum = '0;
    if (m) begin
      case (s)
        4'b0000: f = ~a;        4'b0001: f = ~(a | b);
        4'b0010: f = ~a & b;    4'b0011: f = 4'h0;
        4'b0100: f = ~(a & b);  4'b0101: f = ~b;
        4'b0110: f = a ^ b;     4'b0111: f = a & ~b;
        4'b1000: f = ~a | b;    4'b1001: f = ~(a ^ b);
        4'b1010: f = b;         4'b1011: f = a & b;
        4'b1100: f = 4'hF;      4'b1101: f = a | ~b;
        4'b1110: f = a | b;     default: f = a;
      endcase
    end else begin
      case (s)
        4'b0000: begin x = a;      y = 4'h0;   end
        4'b0001: begin x = a | b;  y = 4'h0;   end
        4'b0010: begin x = a | ~b; y = 4'h0;   end
        4'b0011: begin x = 4'hF;   y = 4'h0;   end
        4'b0100: begin x = a;      y = a & ~b; end
        4'b0101: begin x = a | b;  y = a & ~b; end
        4'b0110: begin x = a;      y = ~b;     end
        4'b0111: begin x = a & ~b; y = 4'hF;   end
        4'b1000: begin x = a;      y = a & b;  end
        4'b1001: begin x = a;      y = b;      end
        4'b1010: begin x = a | ~b; y = a & b;  end
        4'b1011: begin x = a & b;  y = 4'hF;   end
        4'b1100: begin x = a;      y = a;      end
        4'b1101: begin x = a | b;  y = a;      end
        4'b1110: begin x = a | ~b; y = a;      end
        default: begin x = a;      y = 4'hF;   end
      endcase
      sum = {1'b0, x} + {1'b0, y} + {4'b0, cn};
      f   = sum[3:0];
      c4  = sum[4];
    end
    return {(f == 4'hF), c4, f};
  endfunction

  assign {alu_aeqb, alu_cn4, alu_f} = slice(alu_a, alu_b, alu_s, alu_m, alu_cn);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 with result 0x%0h, expected no done", result);
      end else begin
        e = sb.pop_front();
        chk("result", {16'h0, result}, {16'h0, e.res});
        chk("cout", {31'h0, cout}, {31'h0, e.cout});
        chk("aeq", {31'h0, aeq}, {31'h0, e.aeq});
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                        input logic m, input logic cn, input logic [15:0] er,
                        input logic ec, input logic ea, input string nm,
                        output logic [3:0] cn_seen);
    exp_t e;
    int   cyc;
    bit   got;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; op_s = s; op_m = m; op_cn = cn;
    e = '{res: er, cout: ec, aeq: ea};
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; op_a = ~a; op_b = ~b; op_s = ~s; op_m = ~m; op_cn = ~cn;
    cyc = 0; got = 0; cn_seen = '0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc <= 4) cn_seen[cyc-1] = alu_cn;
      if (cyc == 1) chk({nm, "_busy"}, {31'h0, busy}, 32'd1);
      if (done) got = 1;
    end
    chk({nm, "_latency"}, cyc, 32'd5);
    repeat (2) @(negedge clk);
    chk({nm, "_hold"}, {16'h0, result}, {16'h0, er});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] cns;
    exp_t e;
    int   acc0, acc1, nacc, d0;
    logic prev;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {30'h0, busy, done}, 32'd0);
    chk("rst_res", {14'h0, result, cout, aeq}, 32'd0);
    chk("rst_alu", {21'h0, alu_a, alu_b, alu_s, alu_m, alu_cn}, 32'd0);
    rst = 1'b0;

    run_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0101, 1'b0, 1'b0, "t1_add_cin", cns);
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "t2_add_wrap", cns);
    chk("t2_chain_cn", {28'h0, cns}, 32'hE);
    run_op(16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b0, 16'hAA55, 1'b0, 1'b0, "t3_xor", cns);
    run_op(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, "t4_eq", cns);
    run_op(16'h1234, 16'h1235, 4'b0110, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0, "t4_ne", cns);
    run_op(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "t7_sub", cns);
    run_op(16'hF0F0, 16'h3C3C, 4'b1011, 1'b1, 1'b0, 16'h3030, 1'b0, 1'b0, "t8_and", cns);
    run_op(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, "t9_add_msb", cns);

    // start held high for 12 edges: only edges 0 and 6 may accept.
    acc0 = -1; acc1 = -1; nacc = 0; d0 = n_done; prev = busy;
    @(negedge clk);
    start = 1'b1; op_a = 16'h0001; op_b = 16'h0002; op_s = 4'b1001; op_m = 1'b0; op_cn = 1'b0;
    e = '{res: 16'h0003, cout: 1'b0, aeq: 1'b0};
    sb.push_back(e);
    sb.push_back(e);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy && !prev) begin
        if (nacc == 0) acc0 = i;
        else if (nacc == 1) acc1 = i;
        nacc++;
      end
      prev = busy;
      if (i == 11) start = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("t5_accepts", nacc, 32'd2);
    chk("t5_first", acc0, 32'd0);
    chk("t5_second", acc1, 32'd6);
    chk("t5_dones", n_done - d0, 32'd2);

    // Abort with synchronous reset while nibble 2 is on the slice.
    d0 = n_done;
    @(negedge clk);
    start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; op_s = 4'b1111; op_m = 1'b0; op_cn = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_pre_busy", {31'h0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_ctrl", {30'h0, busy, done}, 32'd0);
    chk("t6_res", {14'h0, result, cout, aeq}, 32'd0);
    chk("t6_alu", {21'h0, alu_a, alu_b, alu_s, alu_m, alu_cn}, 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_no_done", n_done - d0, 32'd0);
    run_op(16'hFFFF, 16'h0000, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "t6_restart", cns);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
